// File: rtl/cp0_regfile_pkg.sv
// Shared CP0 definitions: register numbers, decoder exception codes, ExcCode
// values and Status/Cause field positions used by the CP0 register file.
package cp0_regfile_pkg;

    localparam logic [4:0] CP0_BADVADDR = 5'd8;
    localparam logic [4:0] CP0_COUNT    = 5'd9;
    localparam logic [4:0] CP0_COMPARE  = 5'd11;
    localparam logic [4:0] CP0_STATUS   = 5'd12;
    localparam logic [4:0] CP0_CAUSE    = 5'd13;
    localparam logic [4:0] CP0_EPC      = 5'd14;

    // Exception types as delivered by the M-stage exception decoder.
    localparam logic [31:0] EXT_INT     = 32'h01;
    localparam logic [31:0] EXT_ADEL    = 32'h04;
    localparam logic [31:0] EXT_ADES    = 32'h05;
    localparam logic [31:0] EXT_SYSCALL = 32'h08;
    localparam logic [31:0] EXT_BREAK   = 32'h09;
    localparam logic [31:0] EXT_RI      = 32'h0a;
    localparam logic [31:0] EXT_OV      = 32'h0c;
    localparam logic [31:0] EXT_ERET    = 32'h0e;

    typedef enum logic [4:0] {
        EXCCODE_INT  = 5'h00,
        EXCCODE_ADEL = 5'h04,
        EXCCODE_ADES = 5'h05,
        EXCCODE_SYS  = 5'h08,
        EXCCODE_BP   = 5'h09,
        EXCCODE_RI   = 5'h0a,
        EXCCODE_OV   = 5'h0c
    } exccode_e;

    typedef enum logic [1:0] {
        EXC_NONE,
        EXC_TAKE,
        EXC_RETURN
    } exc_kind_e;

    localparam int STATUS_IE     = 0;
    localparam int STATUS_EXL    = 1;
    localparam int STATUS_IM_LO  = 8;
    localparam int STATUS_IM_HI  = 15;
    localparam int CAUSE_EXC_LO  = 2;
    localparam int CAUSE_EXC_HI  = 6;
    localparam int CAUSE_IP_LO   = 8;
    localparam int CAUSE_IP_HI   = 15;
    localparam int CAUSE_TI      = 30;
    localparam int CAUSE_BD      = 31;

    localparam logic [31:0] STATUS_WMASK = 32'h0000_FF03;
    localparam logic [31:0] CAUSE_WMASK  = 32'h0000_0300;

    function automatic logic [31:0] merge_masked(input logic [31:0] old_val,
                                                 input logic [31:0] new_val,
                                                 input logic [31:0] mask);
        return (old_val & ~mask) | (new_val & mask);
    endfunction

endpackage

// File: rtl/cp0_timer.sv
// Count/Compare timer: prescaled Count, Compare match detection and a sticky
// timer interrupt that only an MTC0 to Compare clears.
module cp0_timer #(
    parameter int COUNT_DIV = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        count_we_i,
    input  logic        compare_we_i,
    input  logic [31:0] wdata_i,
    output logic [31:0] count_o,
    output logic [31:0] compare_o,
    output logic        timer_int_o
);
    localparam int DIV_W = (COUNT_DIV > 1) ? $clog2(COUNT_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(COUNT_DIV - 1);

    logic [DIV_W-1:0] div_q, div_d;
    logic [31:0]      count_q, count_d;
    logic [31:0]      compare_q, compare_d;
    logic             timer_int_q, timer_int_d;
    logic             tick;
    logic             match;

    assign tick  = (div_q == DIV_LAST);
    assign match = (compare_q != 32'd0) && (count_q == compare_q);

    always_comb begin
        div_d       = tick ? '0 : div_q + DIV_W'(1);
        count_d     = count_q;
        compare_d   = compare_q;
        timer_int_d = timer_int_q | match;
        // A software Count write replaces the increment but leaves the phase alone.
        if (count_we_i) begin
            count_d = wdata_i;
        end else if (tick) begin
            count_d = count_q + 32'd1;
        end
        if (compare_we_i) begin
            compare_d   = wdata_i;
            timer_int_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            div_q       <= '0;
            count_q     <= '0;
            compare_q   <= '0;
            timer_int_q <= 1'b0;
        end else begin
            div_q       <= div_d;
            count_q     <= count_d;
            compare_q   <= compare_d;
            timer_int_q <= timer_int_d;
        end
    end

    assign count_o     = count_q;
    assign compare_o   = compare_q;
    assign timer_int_o = timer_int_q;

endmodule

// File: rtl/cp0_regfile.sv
// Coprocessor-0 register file: MTC0/MFC0 access, exception/ERET commit of
// Status/Cause/EPC/BadVAddr, and the Count/Compare timer.
module cp0_regfile
    import cp0_regfile_pkg::*;
#(
    parameter logic [31:0] STATUS_RST = 32'h0040_0000,
    parameter int          COUNT_DIV  = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        we,
    input  logic [4:0]  waddr,
    input  logic [31:0] wdata,
    input  logic [4:0]  raddr,
    output logic [31:0] rdata,
    input  logic [5:0]  ext_int,
    input  logic [31:0] except_type,
    input  logic [31:0] except_pc,
    input  logic        in_delayslot,
    input  logic [31:0] bad_addr,
    output logic [31:0] status_o,
    output logic [31:0] cause_o,
    output logic [31:0] epc_o,
    output logic [31:0] count_o,
    output logic [31:0] compare_o,
    output logic [31:0] badvaddr_o,
    output logic        timer_int
);
    logic [31:0] status_q, status_d;
    logic [31:0] cause_q, cause_d;
    logic [31:0] epc_q, epc_d;
    logic [31:0] badvaddr_q, badvaddr_d;
    exc_kind_e   exc_kind;
    exccode_e    exc_code;
    logic        exc_badaddr;
    logic        mtc0_en;
    logic        bypass;

    always_comb begin
        exc_kind    = EXC_NONE;
        exc_code    = EXCCODE_INT;
        exc_badaddr = 1'b0;
        case (except_type)
            EXT_INT:     begin exc_kind = EXC_TAKE; exc_code = EXCCODE_INT;  end
            EXT_ADEL:    begin exc_kind = EXC_TAKE; exc_code = EXCCODE_ADEL; exc_badaddr = 1'b1; end
            EXT_ADES:    begin exc_kind = EXC_TAKE; exc_code = EXCCODE_ADES; exc_badaddr = 1'b1; end
            EXT_SYSCALL: begin exc_kind = EXC_TAKE; exc_code = EXCCODE_SYS;  end
            EXT_BREAK:   begin exc_kind = EXC_TAKE; exc_code = EXCCODE_BP;   end
            EXT_RI:      begin exc_kind = EXC_TAKE; exc_code = EXCCODE_RI;   end
            EXT_OV:      begin exc_kind = EXC_TAKE; exc_code = EXCCODE_OV;   end
            EXT_ERET:    exc_kind = EXC_RETURN;
            default:     exc_kind = EXC_NONE;
        endcase
    end

    // Unrecognised codes behave as no exception, so the MTC0 still lands.
    assign mtc0_en = we && (exc_kind == EXC_NONE);

    cp0_timer #(
        .COUNT_DIV (COUNT_DIV)
    ) u_timer (
        .clk          (clk),
        .rst          (rst),
        .count_we_i   (mtc0_en && (waddr == CP0_COUNT)),
        .compare_we_i (mtc0_en && (waddr == CP0_COMPARE)),
        .wdata_i      (wdata),
        .count_o      (count_o),
        .compare_o    (compare_o),
        .timer_int_o  (timer_int)
    );

    always_comb begin
        status_d   = status_q;
        cause_d    = cause_q;
        epc_d      = epc_q;
        badvaddr_d = badvaddr_q;
        cause_d[CAUSE_IP_HI:CAUSE_IP_HI-5] = {ext_int[5] | timer_int, ext_int[4:0]};
        cause_d[CAUSE_TI]                  = timer_int;
        if (mtc0_en) begin
            case (waddr)
                CP0_STATUS: status_d = merge_masked(status_q, wdata, STATUS_WMASK);
                CP0_CAUSE:  cause_d[CAUSE_IP_LO+1:CAUSE_IP_LO] = wdata[CAUSE_IP_LO+1:CAUSE_IP_LO];
                CP0_EPC:    epc_d = wdata;
                default:    ;
            endcase
        end
        case (exc_kind)
            EXC_TAKE: begin
                // A nested exception keeps the original return point.
                if (!status_q[STATUS_EXL]) begin
                    epc_d             = in_delayslot ? except_pc - 32'd4 : except_pc;
                    cause_d[CAUSE_BD] = in_delayslot;
                end
                cause_d[CAUSE_EXC_HI:CAUSE_EXC_LO] = exc_code;
                status_d[STATUS_EXL]               = 1'b1;
                if (exc_badaddr) begin
                    badvaddr_d = bad_addr;
                end
            end
            EXC_RETURN: status_d[STATUS_EXL] = 1'b0;
            default:    ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            status_q   <= STATUS_RST;
            cause_q    <= '0;
            epc_q      <= '0;
            badvaddr_q <= '0;
        end else begin
            status_q   <= status_d;
            cause_q    <= cause_d;
            epc_q      <= epc_d;
            badvaddr_q <= badvaddr_d;
        end
    end

    // Bypass shows the masked MTC0 value only; exception updates are not forwarded.
    assign bypass = we && (waddr == raddr);

    always_comb begin
        rdata = '0;
        case (raddr)
            CP0_BADVADDR: rdata = badvaddr_q;
            CP0_COUNT:    rdata = bypass ? wdata : count_o;
            CP0_COMPARE:  rdata = bypass ? wdata : compare_o;
            CP0_STATUS:   rdata = bypass ? merge_masked(status_q, wdata, STATUS_WMASK) : status_q;
            CP0_CAUSE:    rdata = bypass ? merge_masked(cause_q, wdata, CAUSE_WMASK) : cause_q;
            CP0_EPC:      rdata = bypass ? wdata : epc_q;
            default:      rdata = '0;
        endcase
    end

    assign status_o   = status_q;
    assign cause_o    = cause_q;
    assign epc_o      = epc_q;
    assign badvaddr_o = badvaddr_q;

endmodule

// File: tb/tb_cp0_regfile.sv
// Directed bench for cp0_regfile: reset, MTC0 masking/bypass, exception and
// ERET commit, and timer divide/match/wrap behaviour with COUNT_DIV=2.
module tb_cp0_regfile;
    logic        clk = 1'b0;
    logic        rst;
    logic        we;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic [4:0]  raddr;
    logic [31:0] rdata;
    logic [5:0]  ext_int;
    logic [31:0] except_type;
    logic [31:0] except_pc;
    logic        in_delayslot;
    logic [31:0] bad_addr;
    logic [31:0] status_o, cause_o, epc_o, count_o, compare_o, badvaddr_o;
    logic        timer_int;

    int n_checks = 0;
    int n_errors = 0;

    cp0_regfile #(
        .STATUS_RST (32'h0040_0000),
        .COUNT_DIV  (2)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .we           (we),
        .waddr        (waddr),
        .wdata        (wdata),
        .raddr        (raddr),
        .rdata        (rdata),
        .ext_int      (ext_int),
        .except_type  (except_type),
        .except_pc    (except_pc),
        .in_delayslot (in_delayslot),
        .bad_addr     (bad_addr),
        .status_o     (status_o),
        .cause_o      (cause_o),
        .epc_o        (epc_o),
        .count_o      (count_o),
        .compare_o    (compare_o),
        .badvaddr_o   (badvaddr_o),
        .timer_int    (timer_int)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_errors++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
        $display("check %-16s observed 0x%08h expected 0x%08h", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        we          = 1'b0;
        except_type = 32'h0;
        in_delayslot = 1'b0;
    endtask

    task automatic mtc0(input logic [4:0] a, input logic [31:0] d);
        we = 1'b1; waddr = a; wdata = d;
        step();
        we = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] c0;
        logic        found;

        rst = 1'b1; we = 1'b0; waddr = '0; wdata = '0; raddr = '0; ext_int = '0;
        except_type = '0; except_pc = '0; in_delayslot = 1'b0; bad_addr = '0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // Reset state
        raddr = 5'd12; #1 check("rst_status", rdata, 32'h0040_0000);
        raddr = 5'd13; #1 check("rst_cause", rdata, 32'h0);
        raddr = 5'd14; #1 check("rst_epc", rdata, 32'h0);
        raddr = 5'd8;  #1 check("rst_badvaddr", rdata, 32'h0);
        check("rst_timer_int", {31'b0, timer_int}, 32'h0);
        check("rst_count", count_o, 32'h0);

        // Status mask and same-cycle bypass
        we = 1'b1; waddr = 5'd12; wdata = 32'hFFFF_FFFF; raddr = 5'd12;
        #1 check("status_bypass", rdata, 32'h0040_FF03);
        step(); we = 1'b0;
        check("status_masked", status_o, 32'h0040_FF03);
        mtc0(5'd12, 32'h0);
        check("status_clear", status_o, 32'h0040_0000);

        // Cause mask
        we = 1'b1; waddr = 5'd13; wdata = 32'hFFFF_FFFF; raddr = 5'd13;
        #1 check("cause_bypass", rdata, 32'h0000_0300);
        step(); we = 1'b0;
        check("cause_masked", cause_o, 32'h0000_0300);
        ext_int = 6'b000101; step();
        check("cause_hw_ip", cause_o, 32'h0000_1700);
        ext_int = 6'b0; step();
        check("cause_hw_ip_clr", cause_o, 32'h0000_0300);

        // Unimplemented register: reads zero even while written
        we = 1'b1; waddr = 5'd5; wdata = 32'hFFFF_FFFF; raddr = 5'd5;
        #1 check("unimpl_read", rdata, 32'h0);
        step(); we = 1'b0;

        // Syscall in delay slot, EXL=0
        except_type = 32'h08; except_pc = 32'hBFC0_0104; in_delayslot = 1'b1;
        step(); idle();
        check("sys_epc", epc_o, 32'hBFC0_0100);
        check("sys_cause", cause_o, 32'h8000_0320);
        check("sys_status", status_o, 32'h0040_0002);

        // Syscall again with EXL=1: EPC and BD hold
        except_type = 32'h08; except_pc = 32'hBFC0_0200; in_delayslot = 1'b0;
        step(); idle();
        check("nest_epc", epc_o, 32'hBFC0_0100);
        check("nest_cause", cause_o, 32'h8000_0320);

        except_type = 32'h0e; step(); idle();
        check("eret1_status", status_o, 32'h0040_0000);

        // AdEL with a dropped same-cycle MTC0 to EPC
        except_type = 32'h04; except_pc = 32'hBFC0_0300; bad_addr = 32'h8000_0003;
        we = 1'b1; waddr = 5'd14; wdata = 32'h0000_1234;
        step(); idle();
        check("adel_badvaddr", badvaddr_o, 32'h8000_0003);
        check("adel_epc", epc_o, 32'hBFC0_0300);
        check("adel_cause", cause_o, 32'h0000_0310);
        check("adel_status", status_o, 32'h0040_0002);
        except_type = 32'h0e; step(); idle();
        check("eret2_status", status_o, 32'h0040_0000);
        check("eret2_epc", epc_o, 32'hBFC0_0300);
        check("eret2_cause", cause_o, 32'h0000_0310);

        // Unknown code: MTC0 proceeds, no exception state change
        except_type = 32'h02; we = 1'b1; waddr = 5'd14; wdata = 32'hCAFE_0000;
        step(); idle();
        check("unk_epc", epc_o, 32'hCAFE_0000);
        check("unk_status", status_o, 32'h0040_0000);

        // Interrupt maps to ExcCode 0
        except_type = 32'h01; except_pc = 32'h8000_1000;
        step(); idle();
        check("int_cause", cause_o, 32'h0000_0300);
        check("int_epc", epc_o, 32'h8000_1000);
        except_type = 32'h0e; step(); idle();

        // Timer match and sticky interrupt
        mtc0(5'd9, 32'h10);
        mtc0(5'd11, 32'h14);
        found = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (count_o == 32'h14) begin
                found = 1'b1;
                break;
            end
            step();
        end
        check("timer_reach", {31'b0, found}, 32'h1);
        check("tint_pre", {31'b0, timer_int}, 32'h0);
        step();
        check("tint_set", {31'b0, timer_int}, 32'h1);
        step();
        check("tint_cause", cause_o, 32'h4000_8300);
        c0 = count_o;
        repeat (8) step();
        check("count_div", count_o, c0 + 32'd4);
        check("tint_sticky", {31'b0, timer_int}, 32'h1);
        mtc0(5'd11, 32'h100);
        check("tint_clear", {31'b0, timer_int}, 32'h0);

        // Count wrap, then MTC0 on a tick cycle
        mtc0(5'd9, 32'hFFFF_FFFF);
        for (int i = 0; i < 4; i++) begin
            if (count_o != 32'hFFFF_FFFF) break;
            step();
        end
        check("count_wrap", count_o, 32'h0);
        step();
        mtc0(5'd9, 32'h5);
        check("count_race", count_o, 32'h5);
        step();
        check("count_hold", count_o, 32'h5);
        step();
        check("count_phase", count_o, 32'h6);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
